// File: rtl/note_tone_gen_if.sv
// Key-scanner side request (key/note/octave) and tone-generator response bundle.
interface note_tone_gen_if;
  logic       key_valid;
  logic [3:0] note;
  logic [2:0] octave;
  logic       tone;
  logic       active;
  logic [3:0] cur_note;
  logic [2:0] cur_octave;

  modport master (output key_valid, note, octave,
                  input  tone, active, cur_note, cur_octave);
  modport slave  (input  key_valid, note, octave,
                  output tone, active, cur_note, cur_octave);
endinterface

// File: rtl/note_tone_gen.sv
// Run-time selectable chromatic square-wave generator (12 notes x octave shifts).
// Note changes land only on falling edges; release always finishes the high phase.
module note_tone_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int CNT_W   = 17,
  parameter int MAX_OCT = 4
) (
  input  logic            clk,
  input  logic            reset,
  note_tone_gen_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PLAY, REL} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tone_q;
  logic             active_q;
  logic [3:0]       note_q;
  logic [2:0]       oct_q;

  function automatic logic [CNT_W-1:0] base_hp(input logic [3:0] n);
    case (n)
      4'd0:    return CNT_W'(CLK_HZ / (2*262));
      4'd1:    return CNT_W'(CLK_HZ / (2*277));
      4'd2:    return CNT_W'(CLK_HZ / (2*294));
      4'd3:    return CNT_W'(CLK_HZ / (2*311));
      4'd4:    return CNT_W'(CLK_HZ / (2*330));
      4'd5:    return CNT_W'(CLK_HZ / (2*349));
      4'd6:    return CNT_W'(CLK_HZ / (2*370));
      4'd7:    return CNT_W'(CLK_HZ / (2*392));
      4'd8:    return CNT_W'(CLK_HZ / (2*415));
      4'd9:    return CNT_W'(CLK_HZ / (2*440));
      4'd10:   return CNT_W'(CLK_HZ / (2*466));
      default: return CNT_W'(CLK_HZ / (2*494));
    endcase
  endfunction

  function automatic logic [2:0] clamp_oct(input logic [2:0] o);
    return (32'(o) > MAX_OCT) ? 3'(MAX_OCT) : o;
  endfunction

  logic [CNT_W-1:0] hp;
  logic             term;
  logic             hold;

  // Half-period always comes from the latched note, never the live inputs.
  assign hp   = base_hp(note_q) >> oct_q;
  assign term = (cnt == hp - 1'b1);
  assign hold = bus.key_valid && (bus.note < 4'd12);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      tone_q   <= 1'b0;
      active_q <= 1'b0;
      note_q   <= '0;
      oct_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt    <= '0;
          tone_q <= 1'b0;
          if (hold) begin
            note_q   <= bus.note;
            oct_q    <= clamp_oct(bus.octave);
            tone_q   <= 1'b1;
            active_q <= 1'b1;
            state    <= PLAY;
          end
        end
        PLAY, REL: begin
          // REL only ever holds tone=1, so both states share the counting path.
          if (term) begin
            cnt    <= '0;
            tone_q <= ~tone_q;
            if (hold && tone_q) begin
              note_q <= bus.note;
              oct_q  <= clamp_oct(bus.octave);
            end
            if (!hold && tone_q) begin
              state    <= IDLE;
              active_q <= 1'b0;
            end else begin
              state <= hold ? PLAY : REL;
            end
          end else if (!hold && !tone_q) begin
            cnt      <= '0;
            state    <= IDLE;
            active_q <= 1'b0;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= hold ? PLAY : REL;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          tone_q   <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tone       = tone_q;
  assign bus.active     = active_q;
  assign bus.cur_note   = note_q;
  assign bus.cur_octave = oct_q;
endmodule
